// File: rtl/chip8_pkg.sv
// Shared CHIP-8 / SUPER-CHIP definitions: display geometry constants and draw FSM states.
package chip8_pkg;

  localparam int unsigned DISP_W_LORES    = 64;
  localparam int unsigned DISP_H_LORES    = 32;
  localparam int unsigned DISP_W_HIRES    = 128;
  localparam int unsigned DISP_H_HIRES    = 64;
  localparam int unsigned SPRITE_ROWS_MAX = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH0,
    ST_FETCH1,
    ST_WRITE,
    ST_DONE
  } draw_state_e;

endpackage

// File: rtl/chip8_sprite_shifter.sv
// Combinational sprite aligner: left-aligns an 8/16-pixel row and moves it to column x.
// CHIP8_DRAW_CLIP_EN selects a plain shift (pixels past the right edge dropped) over a rotate.
module chip8_sprite_shifter
  import chip8_pkg::*;
#(
  parameter int unsigned DISP_W = DISP_W_LORES
) (
  input  logic [15:0]                 spr_i,
  input  logic                        wide_i,
  input  logic [$clog2(DISP_W)-1:0]   x_i,
  output logic [DISP_W-1:0]           spr_o
);

  localparam int unsigned XW = $clog2(DISP_W);

  logic [DISP_W-1:0] left_c;

  always_comb begin
    left_c = '0;
    if (wide_i) begin
      left_c[DISP_W-1 -: 16] = spr_i;
    end else begin
      left_c[DISP_W-1 -: 8] = spr_i[7:0];
    end
  end

`ifdef CHIP8_DRAW_CLIP_EN
  assign spr_o = left_c >> x_i;
`else
  // Left shift by (DISP_W - x) mod DISP_W; at x=0 both terms equal left_c.
  logic [XW-1:0] xn_c;
  assign xn_c  = XW'(0) - x_i;
  assign spr_o = (left_c >> x_i) | (left_c << xn_c);
`endif

endmodule

// File: rtl/chip8_sprite_engine.sv
// Row-serial read-modify-write sprite draw engine for Dxyn (XOR draw with collision flag).
// Build option: CHIP8_DRAW_CLIP_EN clips at the right/bottom edges instead of wrapping.
module chip8_sprite_engine
  import chip8_pkg::*;
#(
  parameter int unsigned DISP_W = DISP_W_LORES,
  parameter int unsigned DISP_H = DISP_H_LORES,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                        instruction_clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  x_in,
  input  logic [7:0]                  y_in,
  input  logic [3:0]                  n_in,
  input  logic                        wide_in,
  input  logic [ADDR_W-1:0]           base_addr,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  vf,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [7:0]                  mem_data,
  output logic                        row_rd,
  output logic                        row_we,
  output logic [$clog2(DISP_H)-1:0]   row_addr,
  input  logic [DISP_W-1:0]           row_rdata,
  output logic [DISP_W-1:0]           row_wdata
);

  localparam int unsigned XW = $clog2(DISP_W);
  localparam int unsigned YW = $clog2(DISP_H);

  draw_state_e       state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [4:0]        rows_q, rows_d;
  logic [3:0]        r_q, r_d;
  logic              wide_q, wide_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        hi_q, hi_d;
  logic              hit_q, hit_d;

  logic [4:0]        rows_req_c;
  logic [4:0]        rows_fit_c;
  logic [15:0]       spr_word_c;
  logic [DISP_W-1:0] spr_c;
  logic              last_row_c;
  logic              unused_c;

  assign unused_c   = ^{x_in[7:XW], y_in[7:YW]};
  assign rows_req_c = (n_in == 4'd0) ? 5'(SPRITE_ROWS_MAX) : {1'b0, n_in};

`ifdef CHIP8_DRAW_CLIP_EN
  // Rows that fit between the start row and the bottom edge.
  logic [7:0] room_c;
  assign room_c     = 8'(DISP_H) - 8'(y_in[YW-1:0]);
  assign rows_fit_c = (room_c < 8'(rows_req_c)) ? 5'(room_c) : rows_req_c;
`else
  assign rows_fit_c = rows_req_c;
`endif

  assign spr_word_c = wide_q ? {hi_q, mem_data} : {8'h00, mem_data};
  assign last_row_c = ({1'b0, r_q} + 5'd1) == rows_q;

  chip8_sprite_shifter #(
    .DISP_W (DISP_W)
  ) u_shifter (
    .spr_i  (spr_word_c),
    .wide_i (wide_q),
    .x_i    (x_q),
    .spr_o  (spr_c)
  );

  always_ff @(posedge instruction_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      rows_q  <= '0;
      r_q     <= '0;
      wide_q  <= 1'b0;
      ptr_q   <= '0;
      hi_q    <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rows_q  <= rows_d;
      r_q     <= r_d;
      wide_q  <= wide_d;
      ptr_q   <= ptr_d;
      hi_q    <= hi_d;
      hit_q   <= hit_d;
    end
  end

  // Next state and state-decoded outputs; everything drops to 0 as soon as reset forces IDLE.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    rows_d    = rows_q;
    r_d       = r_q;
    wide_d    = wide_q;
    ptr_d     = ptr_q;
    hi_d      = hi_q;
    hit_d     = hit_q;
    busy      = 1'b1;
    done      = 1'b0;
    vf        = {7'd0, hit_q};
    mem_rd    = 1'b0;
    mem_addr  = '0;
    row_rd    = 1'b0;
    row_we    = 1'b0;
    row_addr  = '0;
    row_wdata = '0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          x_d     = x_in[XW-1:0];
          y_d     = y_in[YW-1:0];
          rows_d  = rows_fit_c;
          wide_d  = wide_in;
          ptr_d   = base_addr;
          hit_d   = 1'b0;
          r_d     = '0;
          state_d = ST_FETCH0;
        end
      end
      ST_FETCH0: begin
        mem_rd   = 1'b1;
        mem_addr = ptr_q;
        row_rd   = 1'b1;
        row_addr = y_q + YW'(r_q);
        state_d  = wide_q ? ST_FETCH1 : ST_WRITE;
      end
      ST_FETCH1: begin
        mem_rd   = 1'b1;
        mem_addr = ptr_q + ADDR_W'(1);
        hi_d     = mem_data;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        row_we    = 1'b1;
        row_addr  = y_q + YW'(r_q);
        row_wdata = row_rdata ^ spr_c;
        hit_d     = hit_q | (|(row_rdata & spr_c));
        ptr_d     = ptr_q + (wide_q ? ADDR_W'(2) : ADDR_W'(1));
        r_d       = r_q + 4'd1;
        state_d   = last_row_c ? ST_DONE : ST_FETCH0;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_chip8_sprite_engine.sv
// Bench for chip8_sprite_engine: lores (64x32) and hires (128x64) instances against a per-pixel draw model.
module tb_chip8_sprite_engine;
  import chip8_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst;
  logic        start_a, start_b;
  logic [7:0]  x_in, y_in;
  logic [3:0]  n_in;
  logic        wide_in;
  logic [11:0] base_addr;

  logic         busy_a, done_a, mem_rd_a, row_rd_a, row_we_a;
  logic [7:0]   vf_a, mem_data_a;
  logic [11:0]  mem_addr_a;
  logic [4:0]   row_addr_a;
  logic [63:0]  row_rdata_a, row_wdata_a;

  logic         busy_b, done_b, mem_rd_b, row_rd_b, row_we_b;
  logic [7:0]   vf_b, mem_data_b;
  logic [11:0]  mem_addr_b;
  logic [5:0]   row_addr_b;
  logic [127:0] row_rdata_b, row_wdata_b;

  logic [7:0]   mem [4096];
  logic [63:0]  disp_a [32];
  logic [127:0] disp_b [64];
  logic [127:0] mdl [2][64];
  int wlog[$], mlog[$], exp_rows[$], exp_addrs[$];

  logic         ld_en = 1'b0;
  logic         ld_sel;
  logic [5:0]   ld_row;
  logic [127:0] ld_val;

  chip8_sprite_engine u_dut_a (
    .instruction_clk (clk),        .rst       (rst),
    .start           (start_a),    .x_in      (x_in),
    .y_in            (y_in),       .n_in      (n_in),
    .wide_in         (wide_in),    .base_addr (base_addr),
    .busy            (busy_a),     .done      (done_a),
    .vf              (vf_a),       .mem_rd    (mem_rd_a),
    .mem_addr        (mem_addr_a), .mem_data  (mem_data_a),
    .row_rd          (row_rd_a),   .row_we    (row_we_a),
    .row_addr        (row_addr_a), .row_rdata (row_rdata_a),
    .row_wdata       (row_wdata_a)
  );

  chip8_sprite_engine #(.DISP_W(128), .DISP_H(64), .ADDR_W(12)) u_dut_b (
    .instruction_clk (clk),        .rst       (rst),
    .start           (start_b),    .x_in      (x_in),
    .y_in            (y_in),       .n_in      (n_in),
    .wide_in         (wide_in),    .base_addr (base_addr),
    .busy            (busy_b),     .done      (done_b),
    .vf              (vf_b),       .mem_rd    (mem_rd_b),
    .mem_addr        (mem_addr_b), .mem_data  (mem_data_b),
    .row_rd          (row_rd_b),   .row_we    (row_we_b),
    .row_addr        (row_addr_b), .row_rdata (row_rdata_b),
    .row_wdata       (row_wdata_b)
  );

  // Memory and row-buffer environment, plus access logs
  always @(posedge clk) begin
    if (mem_rd_a) begin mem_data_a <= mem[mem_addr_a]; mlog.push_back(int'(mem_addr_a)); end
    if (mem_rd_b) begin mem_data_b <= mem[mem_addr_b]; mlog.push_back(int'(mem_addr_b)); end
    if (row_rd_a) row_rdata_a <= disp_a[row_addr_a];
    if (row_rd_b) row_rdata_b <= disp_b[row_addr_b];
    if (row_we_a) begin disp_a[row_addr_a] <= row_wdata_a; wlog.push_back(int'(row_addr_a)); end
    if (row_we_b) begin disp_b[row_addr_b] <= row_wdata_b; wlog.push_back(int'(row_addr_b)); end
    if (ld_en) begin
      if (ld_sel) disp_b[ld_row] <= ld_val;
      else        disp_a[ld_row[4:0]] <= ld_val[63:0];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_row(input int sel, input int row, input logic [127:0] val);
    @(negedge clk);
    ld_en  = 1'b1;
    ld_sel = sel[0];
    ld_row = 6'(row);
    ld_val = (sel == 0) ? {64'd0, val[63:0]} : val;
    mdl[sel][row] = ld_val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic fill(input int sel, input int mode);
    logic [127:0] v;
    for (int r = 0; r < (sel ? 64 : 32); r++) begin
      if (mode == 0)      v = '0;
      else if (mode == 1) v = {$urandom, $urandom, $urandom, $urandom};
      else                v = '1;
      set_row(sel, r, v);
    end
  endtask

  // Per-pixel XOR draw on the model display; returns expected latency and VF.
  task automatic model_draw(input int sel, input int x, input int y, input int n, input bit wide,
                            input int base, output int lat, output logic [7:0] vf_e);
    int w, h, xs, ys, rows, bw, drawn, hit, py, px;
    logic [15:0] bits;
    w = sel ? 128 : 64;
    h = sel ? 64 : 32;
    xs = x % w;
    ys = y % h;
    rows = (n == 0) ? 16 : n;
    bw = wide ? 16 : 8;
    drawn = 0;
    hit = 0;
    exp_rows.delete();
    exp_addrs.delete();
    for (int i = 0; i < rows; i++) begin
      py = ys + i;
`ifdef CHIP8_DRAW_CLIP_EN
      if (py >= h) break;
`endif
      py = py % h;
      exp_rows.push_back(py);
      if (wide) begin
        bits = {mem[(base + 2 * i) % 4096], mem[(base + 2 * i + 1) % 4096]};
        exp_addrs.push_back((base + 2 * i) % 4096);
        exp_addrs.push_back((base + 2 * i + 1) % 4096);
      end else begin
        bits = {mem[(base + i) % 4096], 8'h00};
        exp_addrs.push_back((base + i) % 4096);
      end
      for (int j = 0; j < bw; j++) begin
        if (bits[15 - j]) begin
          px = xs + j;
`ifdef CHIP8_DRAW_CLIP_EN
          if (px >= w) continue;
`endif
          px = px % w;
          if (mdl[sel][py][w - 1 - px]) hit = 1;
          mdl[sel][py][w - 1 - px] = !mdl[sel][py][w - 1 - px];
        end
      end
      drawn++;
    end
    lat  = (wide ? 3 : 2) * drawn + 1;
    vf_e = (hit != 0) ? 8'h01 : 8'h00;
  endtask

  task automatic chk_disp(input string tag, input int sel);
    int bad;
    logic [127:0] got;
    bad = 0;
    for (int r = 0; r < (sel ? 64 : 32); r++) begin
      got = sel ? disp_b[r] : {64'd0, disp_a[r]};
      if (got !== mdl[sel][r]) bad++;
    end
    chk(tag, 128'(bad), 128'd0);
  endtask

  // One draw; with hold=1 start stays high (with junk operands) through busy and DONE.
  task automatic run_draw(input int sel, input int x, input int y, input int n, input bit wide,
                          input int base, input bit hold);
    int lat_e, lat, bad;
    logic [7:0] vf_e;
    bit seen;
    model_draw(sel, x, y, n, wide, base, lat_e, vf_e);
    @(negedge clk);
    wlog.delete();
    mlog.delete();
    x_in = 8'(x); y_in = 8'(y); n_in = 4'(n); wide_in = wide; base_addr = 12'(base);
    start_a = (sel == 0);
    start_b = (sel == 1);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 120) begin
      @(negedge clk);
      lat++;
      if (hold) begin
        x_in = 8'($urandom); y_in = 8'($urandom); n_in = 4'($urandom);
        wide_in = ~wide; base_addr = 12'($urandom);
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      seen = (sel == 0) ? done_a : done_b;
    end
    chk("done_seen", 128'(seen), 128'd1);
    chk("latency", 128'(lat), 128'(lat_e));
    chk("vf", 128'(sel ? vf_b : vf_a), 128'(vf_e));
    chk("row_writes", 128'(wlog.size()), 128'(exp_rows.size()));
    bad = 0;
    foreach (exp_rows[i]) if (i >= wlog.size() || wlog[i] != exp_rows[i]) bad++;
    chk("row_order", 128'(bad), 128'd0);
    chk("mem_reads", 128'(mlog.size()), 128'(exp_addrs.size()));
    bad = 0;
    foreach (exp_addrs[i]) if (i >= mlog.size() || mlog[i] != exp_addrs[i]) bad++;
    chk("mem_addrs", 128'(bad), 128'd0);
    chk_disp("display", sel);
    if (!hold) begin
      @(negedge clk);
      chk("busy_clear", 128'(sel ? busy_b : busy_a), 128'd0);
      chk("vf_hold", 128'(sel ? vf_b : vf_a), 128'(vf_e));
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    x_in = '0; y_in = '0; n_in = '0; wide_in = 1'b0; base_addr = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h200] = 8'hF0;
    mem[12'h210] = 8'hFF;
    mem[12'h220] = 8'h81;
    mem[12'h221] = 8'h42;
    mem[12'h300] = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy_a), 128'd0);
    chk("rst_outs", 128'({done_a, mem_rd_a, row_rd_a, row_we_a, vf_a}), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", 128'({busy_b, done_b, mem_rd_b, row_rd_b, row_we_b, vf_b}), 128'd0);

    // Directed edge cases on a cleared lores display
    fill(0, 0);
    run_draw(0, 0, 0, 1, 1'b0, 12'h200, 1'b0);
    chk("basic_row0", 128'(disp_a[0]), 128'(64'hF000_0000_0000_0000));
    run_draw(0, 0, 0, 1, 1'b0, 12'h200, 1'b0);
    chk("coll_row0", 128'(disp_a[0]), 128'd0);
    chk("coll_vf", 128'(vf_a), 128'h01);
    run_draw(0, 60, 0, 1, 1'b0, 12'h210, 1'b0);
`ifdef CHIP8_DRAW_CLIP_EN
    chk("hedge_row0", 128'(disp_a[0]), 128'(64'h0000_0000_0000_000F));
`else
    chk("hedge_row0", 128'(disp_a[0]), 128'(64'hF000_0000_0000_000F));
`endif
    run_draw(0, 3, 31, 2, 1'b0, 12'h220, 1'b0);

    // start while busy (and in DONE) ignored; start the cycle after DONE accepted
    run_draw(0, 5, 3, 3, 1'b0, 12'h230, 1'b1);
    run_draw(0, 70, 40, 2, 1'b1, 12'h240, 1'b0);

    // Randomised lores draws over a random display
    fill(0, 1);
    for (int k = 0; k < 16; k++)
      run_draw(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 4095)), 1'b0);

    // Hires wide draw wrapping the address space, then a few random hires draws
    fill(1, 1);
    run_draw(1, 9, 60, 0, 1'b1, 12'hFFF, 1'b0);
    for (int k = 0; k < 4; k++)
      run_draw(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 4095)), 1'b0);

    // Reset during the WRITE of row 3
    fill(0, 2);
    @(negedge clk);
    wlog.delete();
    mlog.delete();
    x_in = 8'd0; y_in = 8'd0; n_in = 4'd6; wide_in = 1'b0; base_addr = 12'h300;
    start_a = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      start_a = 1'b0;
      cnt++;
    end while (!(row_we_a && wlog.size() == 3) && cnt < 100);
    chk("rst_reach_row3", 128'(cnt < 100), 128'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy_a), 128'd0);
    chk("midrst_we", 128'(row_we_a), 128'd0);
    chk("midrst_done", 128'(done_a), 128'd0);
    chk("midrst_vf", 128'(vf_a), 128'd0);
    @(posedge clk);
    #1;
    chk("midrst_no_write", 128'(wlog.size()), 128'd3);
    @(negedge clk);
    rst = 1'b0;
    fill(0, 0);
    run_draw(0, 17, 9, 4, 1'b1, 12'h200, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_sprite_engine.md
# chip8_sprite_engine

Multi-cycle, parametrised sprite draw engine for the CHIP-8 / SUPER-CHIP core. It replaces the single-cycle whole-display XOR draw with a row-serial read-modify-write engine. That engine supports configurable display geometry (64x32 lores, 128x64 hires) and 8- or 16-pixel-wide sprites. The core's instruction sequencer starts it on a Dxyn opcode and stalls until `done`. The engine fetches sprite bytes from main memory and updates an external display row buffer.

## Interface
- `DISP_W`, default 64: display width in pixels; power of two, 64..128.
- `DISP_H`, default 32: display height in rows; power of two, 32..64.
- `ADDR_W`, default 12: memory address width.
- `instruction_clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  draw request; accepted only when `busy`=0.
- `x_in`  in  8  sprite X (VX).
- `y_in`  in  8  sprite Y (VY).
- `n_in`  in  4  row count; 0 means 16 rows.
- `wide_in`  in  1  1 = 16-pixel rows (2 bytes/row), 0 = 8-pixel rows.
- `base_addr`  in  ADDR_W  sprite address (I).
- `busy`  out  1  high while a draw is in progress.
- `done`  out  1  one-cycle completion pulse.
- `vf`  out  8  collision result, {7'b0, hit}; valid from `done` until the next accepted `start`.
- `mem_rd`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_data`  in  8  read data, valid exactly one cycle after `mem_rd`.
- `row_rd`  out  1  display row read strobe.
- `row_we`  out  1  display row write strobe.
- `row_addr`  out  $clog2(DISP_H)  row index.
- `row_rdata`  in  DISP_W  row data. It is valid one cycle after `row_rd` and held stable until the next `row_rd`.
- `row_wdata`  out  DISP_W  row write data. Bit DISP_W-1 is pixel x=0.

## Operation
- States: IDLE, FETCH0, FETCH1, WRITE, DONE.
- **IDLE.** On `start`, latch:
  - `x = x_in mod DISP_W` and `y = y_in mod DISP_H`;
  - `rows = (n_in==0) ? 16 : n_in`;
  - `wide` and `ptr = base_addr`.
  - Clear `hit` and the row counter `r`, then go to FETCH0.
- **FETCH0.** Assert `mem_rd` with `mem_addr=ptr`. Assert `row_rd` with `row_addr=(y+r) mod DISP_H`. Go to FETCH1 if `wide`, else to WRITE.
- **FETCH1.** Capture `mem_data` as the high byte. Assert `mem_rd` with `mem_addr=ptr+1`. Go to WRITE.
- **WRITE.**
  - Form the sprite word: 8-bit narrow, or {hi, lo} for wide. Left-align it in DISP_W bits and rotate it right by `x`.
  - Drive `row_we=1` and `row_wdata = row_rdata ^ spr`.
  - Set `hit |= |(row_rdata & spr)`.
  - Update `ptr += wide?2:1` (mod 2^ADDR_W) and `r += 1`.
  - Go to DONE if `r+1==rows`, else to FETCH0.
- **DONE.** Pulse `done` and present `vf`. Return to IDLE.
- `busy` is high in FETCH0, FETCH1, WRITE and DONE.
- A `start` while `busy` is high is ignored, including in the DONE cycle.
- Reset, at any time including mid-draw:
  - State returns to IDLE; all outputs are 0 (`vf`=0).
  - In-flight row writes are abandoned; no partial write completes after `rst` rises.

## Timing
- Narrow sprite: 2 cycles per row. `done` is asserted 2·rows+1 cycles after the `start` cycle.
- Wide sprite: 3 cycles per row. `done` is asserted 3·rows+1 cycles after the `start` cycle.
- Exactly one `row_we` per drawn row, in the WRITE state.
- Memory accesses per draw: rows or 2·rows.
- `mem_addr` wraps from 2^ADDR_W−1 to 0.

## Configuration
- `CHIP8_DRAW_CLIP_EN` defined:
  - Horizontal: `spr` is shifted right without rotation; pixels past the right edge are dropped.
  - Vertical: the draw terminates, going to DONE after the last row with `y+r < DISP_H`. Rows at or beyond the bottom are never read or written, and the latency shrinks accordingly.
- `CHIP8_DRAW_CLIP_EN` undefined: the sprite wraps horizontally by rotation and vertically mod DISP_H.
- In both cases the start coordinates are always reduced modulo the display size.

## Structure
- Shared package `chip8_pkg`:
  - draw state enum;
  - default DISP_W/DISP_H (lores and hires constants);
  - `SPRITE_ROWS_MAX = 16`.
- One combinational sub-module, `chip8_sprite_shifter`. It takes (sprite word, wide, x) and produces the DISP_W-bit aligned sprite, with the rotate/clip choice selected by the macro. The engine computes the collision and XOR from its output.

## Test plan
All scenarios use the 64x32 defaults unless noted.
- Narrow basic: x=0, y=0, n=1, mem=F0, row 0 = 0 → `row_wdata`=F000…0. `vf`=0. `done` 3 cycles after `start`.
- Collision: repeat the same draw with row 0 = F000…0 → `row_wdata`=0, `vf`=01.
- Horizontal edge: x=60, mem=FF, row=0.
  - Wrap → `row_wdata`=F000_0000_0000_000F.
  - Clip → `row_wdata`=0000_0000_0000_000F.
- Vertical edge: y=31, n=2.
  - Wrap → writes to rows 31 then 0; `done` at cycle 5.
  - Clip → only row 31 is written; `done` at cycle 3.
- Wide hires: DISP_W=128, DISP_H=64, `wide`=1, n=0, base_addr=FFF.
  - 16 row writes and 32 reads; addresses FFF, 000, 001…
  - `done` at cycle 49.
- Reset mid-draw and busy `start`:
  - Assert `rst` in the WRITE state of row 3 → `busy`, `row_we`, `done` and `vf` all 0 immediately.
  - A `start` during `busy` is ignored; a `start` the cycle after DONE is accepted.
